// File: rtl/result_collector.sv
// result_collector: packet-locked round-robin merge of NUM_SOLVERS result streams into one registered stream.
// Optional RESULT_COLLECTOR_TAG_EN adds a registered out_source tag per beat.
module result_collector #(
  parameter int NUM_SOLVERS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SOLVERS*32-1:0]  in_data,
  input  logic [NUM_SOLVERS-1:0]     in_valid,
  input  logic [NUM_SOLVERS-1:0]     in_end_of_stream,
  output logic [NUM_SOLVERS-1:0]     in_ready,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  output logic                       out_end_of_stream,
`ifdef RESULT_COLLECTOR_TAG_EN
  output logic [(NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1)-1:0] out_source,
`endif
  input  logic                       out_ready
);
  localparam int SW = NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_SOLVERS - 1);
  typedef enum logic {ST_SELECT_INPUT, ST_FORWARD} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] rr_q, rr_d, active_q, active_d, pick;
  logic [SW:0] idx;
  logic found, accept, act_eos;
  logic [31:0] act_data, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_eos_q, out_eos_d;
  assign act_data = in_data[{active_q, 5'd0} +: 32];
  assign act_eos = in_end_of_stream[active_q];
  // Descending scan so the lowest offset from rr wins.
  always_comb begin
    pick = rr_q;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (SW+1)'(k);
      idx = idx >= (SW+1)'(NUM_SOLVERS) ? idx - (SW+1)'(NUM_SOLVERS) : idx;
      if (in_valid[idx[SW-1:0]]) begin
        pick = idx[SW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    active_d = active_q;
    in_ready = '0;
    accept = 1'b0;
    if (state_q == ST_SELECT_INPUT) begin
      active_d = found ? pick : active_q;
      state_d = found ? ST_FORWARD : ST_SELECT_INPUT;
    end else begin
      in_ready[active_q] = !out_valid_q || out_ready;
      accept = in_valid[active_q] && (!out_valid_q || out_ready);
      if (accept && act_eos) begin
        rr_d = active_q == LAST ? '0 : active_q + 1'b1;
        state_d = ST_SELECT_INPUT;
      end
    end
  end
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d = accept ? act_data : out_data_q;
    out_eos_d = accept ? act_eos : out_eos_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SELECT_INPUT;
      rr_q <= '0;
      active_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_eos_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      active_q <= active_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_eos_q <= out_eos_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_end_of_stream = out_eos_q;
`ifdef RESULT_COLLECTOR_TAG_EN
  logic [SW-1:0] out_source_q, out_source_d;
  assign out_source_d = accept ? active_q : out_source_q;
  always_ff @(posedge clock) begin
    if (reset) out_source_q <= '0;
    else out_source_q <= out_source_d;
  end
  assign out_source = out_source_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: vector table, directed corner sequences and randomized traffic vs a packet-level round-robin model.
module tb_result_collector;
  localparam int NS = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NS*32-1:0] in_data;
  logic [NS-1:0] in_valid, in_end_of_stream, in_ready;
  logic [31:0] out_data;
  logic out_valid, out_end_of_stream, out_ready;
`ifdef RESULT_COLLECTOR_TAG_EN
  logic out_source;
`endif
  result_collector #(.NUM_SOLVERS(NS)) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_end_of_stream(in_end_of_stream),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_end_of_stream(out_end_of_stream),
`ifdef RESULT_COLLECTOR_TAG_EN
    .out_source(out_source),
`endif
    .out_ready(out_ready)
  );
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] data; logic eos; logic first;} beat_t;
  typedef struct {int src; logic [31:0] data; logic eos;} exp_t;
  typedef struct {
    logic rst; logic [1:0] iv, ie; logic [31:0] d0, d1; logic ordy;
    logic [1:0] xr; logic xv; logic [31:0] xd; logic xe; logic xs;
  } vec_t;
  beat_t sq[NS][$];
  exp_t exp_out[$];
  int exp_in[$];
  int model_rr = 0;
  vec_t tbl[16];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = '0;
    in_end_of_stream = '0;
    in_data = '0;
    out_ready = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_out.delete();
    exp_in.delete();
    model_rr = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic add_pkt(int s, int n);
    for (int k = 0; k < n; k++) sq[s].push_back('{$urandom, k == n - 1, k == 0});
  endtask

  // Whole packets are granted in round-robin order among solvers that still have data.
  task automatic build_expect();
    beat_t tmp[NS][$];
    beat_t b;
    int s;
    int left;
    for (int i = 0; i < NS; i++) tmp[i] = sq[i];
    left = 0;
    for (int i = 0; i < NS; i++) left += tmp[i].size();
    while (left > 0) begin
      for (int k = 0; k < NS; k++) begin
        s = (model_rr + k) % NS;
        if (tmp[s].size() > 0) begin
          do begin
            b = tmp[s].pop_front();
            left--;
            exp_out.push_back('{s, b.data, b.eos});
            exp_in.push_back(s);
          end while (!b.eos);
          model_rr = (s + 1) % NS;
          break;
        end
      end
    end
  endtask

  task automatic run_traffic(int ordy_pct, int drop_pct, int bp_at, int drop_at);
    int cyc = 0;
    logic hold = 1'b0;
    logic [31:0] held = '0;
    logic [NS-1:0] lock_mask;
    logic v;
    build_expect();
    while (exp_out.size() > 0 && cyc < 3000) begin
      @(negedge clock);
      for (int i = 0; i < NS; i++) begin
        v = sq[i].size() > 0;
        if (v && !sq[i][0].first)
          v = $urandom_range(99) >= drop_pct && !(i == 0 && cyc >= drop_at && cyc < drop_at + 3);
        in_valid[i] = v;
        in_end_of_stream[i] = v && sq[i][0].eos;
        in_data[32*i +: 32] = v ? sq[i][0].data : 32'h0;
      end
      out_ready = (cyc >= bp_at && cyc < bp_at + 4) ? 1'b0 : ($urandom_range(99) < ordy_pct);
      #1;
      chk("in_ready_onehot", {31'b0, $onehot0(in_ready)}, 1);
      if (exp_in.size() > 0) begin
        lock_mask = '1;
        lock_mask[exp_in[0]] = 1'b0;
        chk("in_ready_lock", in_ready & lock_mask, 0);
      end else chk("in_ready_idle", in_ready, 0);
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_out[0].data);
        chk("out_eos", out_end_of_stream, exp_out[0].eos);
`ifdef RESULT_COLLECTOR_TAG_EN
        chk("out_source", out_source, exp_out[0].src);
`endif
        void'(exp_out.pop_front());
      end
      for (int i = 0; i < NS; i++)
        if (in_valid[i] && in_ready[i]) begin
          chk("in_order", i, exp_in.size() > 0 ? exp_in[0] : -1);
          void'(sq[i].pop_front());
          if (exp_in.size() > 0) void'(exp_in.pop_front());
        end
      hold = out_valid && !out_ready;
      held = out_data;
      cyc++;
    end
    if (exp_out.size() > 0) chk("timeout_beats_left", exp_out.size(), 0);
    @(negedge clock);
    idle();
    #1;
    chk("drained", out_valid, 0);
  endtask

  initial begin
    idle();
    tbl = '{
      '{1, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 0, 32'h0,  0, 0},
      '{0, 2'b01, 2'b00, 32'h11, 32'h0,  1, 2'b00, 0, 32'h0,  0, 0},
      '{0, 2'b01, 2'b00, 32'h11, 32'h0,  1, 2'b01, 0, 32'h0,  0, 0},
      '{0, 2'b01, 2'b00, 32'h22, 32'h0,  1, 2'b01, 1, 32'h11, 0, 0},
      '{0, 2'b01, 2'b01, 32'h33, 32'h0,  1, 2'b01, 1, 32'h22, 0, 0},
      '{0, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 1, 32'h33, 1, 0},
      '{0, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 0, 32'h0,  0, 0},
      '{1, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 0, 32'h0,  0, 0},
      '{0, 2'b11, 2'b00, 32'hA0, 32'hB0, 1, 2'b00, 0, 32'h0,  0, 0},
      '{0, 2'b11, 2'b00, 32'hA0, 32'hB0, 1, 2'b01, 0, 32'h0,  0, 0},
      '{0, 2'b11, 2'b01, 32'hA1, 32'hB0, 1, 2'b01, 1, 32'hA0, 0, 0},
      '{0, 2'b10, 2'b00, 32'h0,  32'hB0, 1, 2'b00, 1, 32'hA1, 1, 0},
      '{0, 2'b10, 2'b00, 32'h0,  32'hB0, 1, 2'b10, 0, 32'h0,  0, 0},
      '{0, 2'b10, 2'b10, 32'h0,  32'hB1, 1, 2'b10, 1, 32'hB0, 0, 1},
      '{0, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 1, 32'hB1, 1, 1},
      '{0, 2'b00, 2'b00, 32'h0,  32'h0,  1, 2'b00, 0, 32'h0,  0, 0}
    };
    repeat (2) @(negedge clock);
    for (int r = 0; r < 16; r++) begin
      @(negedge clock);
      reset = tbl[r].rst;
      in_valid = tbl[r].iv;
      in_end_of_stream = tbl[r].ie;
      in_data = {tbl[r].d1, tbl[r].d0};
      out_ready = tbl[r].ordy;
      #1;
      if (!tbl[r].rst) begin
        chk($sformatf("row%0d_in_ready", r), in_ready, tbl[r].xr);
        chk($sformatf("row%0d_out_valid", r), out_valid, tbl[r].xv);
        if (tbl[r].xv) begin
          chk($sformatf("row%0d_out_data", r), out_data, tbl[r].xd);
          chk($sformatf("row%0d_out_eos", r), out_end_of_stream, tbl[r].xe);
`ifdef RESULT_COLLECTOR_TAG_EN
          chk($sformatf("row%0d_out_source", r), out_source, tbl[r].xs);
`endif
        end
      end
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
    end
    run_traffic(100, 0, -100, -100);
    do_reset();
    add_pkt(0, 6);
    run_traffic(100, 0, 4, -100);
    do_reset();
    add_pkt(0, 6);
    add_pkt(1, 2);
    run_traffic(100, 0, -100, 3);
    do_reset();
    @(negedge clock);
    in_valid = 2'b10;
    in_data = {32'h55, 32'h0};
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_eos", out_end_of_stream, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef RESULT_COLLECTOR_TAG_EN
    chk("rst_out_source", out_source, 0);
`endif
    clear_model();
    add_pkt(1, 3);
    run_traffic(100, 0, -100, -100);
    for (int round = 0; round < 20; round++) begin
      for (int s = 0; s < NS; s++)
        for (int p = $urandom_range(3); p > 0; p--) add_pkt(s, $urandom_range(1, 4));
      run_traffic(70, 30, -100, -100);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
